// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one push/pop stack between two requesters.
// Full/empty are checked before a strobe is issued, so refused operations never touch the stack.
module stack_arbiter #(
    parameter int WL = 32,
    parameter int N  = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          req0,
    input  logic          req1,
    input  logic          op0,
    input  logic          op1,
    input  logic [WL-1:0] din0,
    input  logic [WL-1:0] din1,
    output logic          ack0,
    output logic          ack1,
    output logic [WL-1:0] rdata,
    output logic          rerr,
    output logic          busy,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [WL-1:0] stk_dio,
    input  logic          stk_full,
    input  logic          stk_empty,
    input  logic          stk_error,
    input  logic [WL-1:0] stk_data
);

    if (WL < 1 || N < 1) begin : g_bad_param
        $error("stack_arbiter: WL and N must be positive");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state;
    logic          last_gnt;
    logic          op_q;
    logic          refused_q;
    logic          rerr_q;
    logic [WL-1:0] rdata_q;

    logic          win;
    logic          win_op;
    logic [WL-1:0] win_din;
    logic          win_refuse;
    logic          rerr_now;
    logic          pop_ok;

    always_comb begin
        win        = (req0 && req1) ? ~last_gnt : req1;
        win_op     = win ? op1 : op0;
        win_din    = win ? din1 : din0;
        win_refuse = win_op ? stk_full : stk_empty;
        rerr_now   = refused_q | stk_error;
        pop_ok     = ~op_q & ~rerr_now;
    end

    // The stack loads its data/error registers at the strobe's closing edge, so during RESP
    // they are forwarded straight through and captured for holding when RESP ends.
    assign rerr  = (state == RESP) ? rerr_now : rerr_q;
    assign rdata = (state == RESP && pop_ok) ? stk_data : rdata_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            op_q      <= 1'b0;
            refused_q <= 1'b0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_dio   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last_gnt  <= win;
                        op_q      <= win_op;
                        refused_q <= win_refuse;
                        busy      <= 1'b1;
                        if (win_refuse) begin
                            state <= RESP;
                            ack0  <= ~win;
                            ack1  <= win;
                        end else begin
                            state    <= ISSUE;
                            stk_push <= win_op;
                            stk_pop  <= ~win_op;
                            stk_dio  <= win_din;
                        end
                    end
                end
                ISSUE: begin
                    stk_push <= 1'b0;
                    stk_pop  <= 1'b0;
                    ack0     <= ~last_gnt;
                    ack1     <= last_gnt;
                    state    <= RESP;
                end
                RESP: begin
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    busy   <= 1'b0;
                    rerr_q <= rerr_now;
                    if (pop_ok)
                        rdata_q <= stk_data;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized scoreboard bench for stack_arbiter with a behavioural stack attached to its stack port.
module tb_stack_arbiter;
    localparam int WL = 32;
    localparam int N  = 32;

    logic          CLK, RESET;
    logic          req0, req1, op0, op1;
    logic [WL-1:0] din0, din1;
    logic          ack0, ack1, rerr, busy, stk_push, stk_pop;
    logic [WL-1:0] rdata, stk_dio, stk_data;
    logic          stk_full, stk_empty, stk_error;

    stack_arbiter #(.WL(WL), .N(N)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1), .din0(din0), .din1(din1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .rerr(rerr), .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_dio(stk_dio),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error), .stk_data(stk_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Attached stack: registered data/error, updated on the strobe's closing edge.
    logic [WL-1:0] smem [N];
    int sp_cnt;
    assign stk_full  = (sp_cnt == N);
    assign stk_empty = (sp_cnt == 0);
    always @(posedge CLK) begin
        if (RESET) begin
            sp_cnt    <= 0;
            stk_data  <= '0;
            stk_error <= 1'b0;
        end else begin
            stk_error <= (stk_push && stk_pop) || (stk_push && sp_cnt == N) || (stk_pop && sp_cnt == 0);
            if (stk_push && !stk_pop && sp_cnt < N) begin
                smem[sp_cnt] <= stk_dio;
                sp_cnt       <= sp_cnt + 1;
            end else if (stk_pop && !stk_push && sp_cnt > 0) begin
                stk_data <= smem[sp_cnt-1];
                sp_cnt   <= sp_cnt - 1;
            end
        end
    end

    int cyc;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit            who;
        bit            rerr;
        logic [WL-1:0] rdata;
        int            lat;
    } exp_t;

    exp_t          sbq[$];
    logic [WL-1:0] ref_stk[$];
    logic [WL-1:0] rdata_m;
    bit            last_m;
    int            n_chk, n_fail;
    int            round_t, strobes;
    bit            prev_strobe;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ack is matched against the next scoreboard entry.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_strobe = 1'b0;
        end else begin
            if (stk_push || stk_pop) begin
                strobes++;
                check("dual_strobe", {stk_push, stk_pop}, {1'b0, 1'b1} << stk_push);
                check("strobe_one_cycle", prev_strobe, 0);
            end
            prev_strobe = stk_push || stk_pop;
            if (ack0 || ack1) begin
                check("single_ack", ack0 && ack1, 0);
                if (sbq.size() == 0) begin
                    check("unexpected_ack", {ack1, ack0}, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_who", ack1, e.who);
                    check("ack_rerr", rerr, e.rerr);
                    check("ack_rdata", rdata, e.rdata);
                    check("ack_latency", cyc - round_t, e.lat);
                end
            end
        end
    end

    task automatic model_op(input bit who, input bit op, input logic [WL-1:0] d, input int base,
                            output int lat, output bit issued);
        exp_t e;
        bit   rf;
        rf = op ? (ref_stk.size() == N) : (ref_stk.size() == 0);
        if (!rf) begin
            if (op) ref_stk.push_back(d);
            else    rdata_m = ref_stk.pop_back();
        end
        lat     = base + (rf ? 1 : 2);
        issued  = !rf;
        e.who   = who;
        e.rerr  = rf;
        e.rdata = rdata_m;
        e.lat   = lat;
        sbq.push_back(e);
        last_m  = who;
    endtask

    task automatic do_round(input bit r0, input bit o0, input logic [WL-1:0] d0,
                            input bit r1, input bit o1, input logic [WL-1:0] d1);
        int l1, l2, ns;
        bit is1, is2, first, p0, p1;
        ns    = 0;
        first = (r0 && r1) ? !last_m : r1;
        model_op(first, first ? o1 : o0, first ? d1 : d0, 0, l1, is1);
        ns += int'(is1);
        if (r0 && r1) begin
            model_op(!first, first ? o0 : o1, first ? d0 : d1, l1 + 1, l2, is2);
            ns += int'(is2);
        end
        strobes = 0;
        round_t = cyc;
        req0 = r0; op0 = o0; din0 = d0;
        req1 = r1; op1 = o1; din1 = d1;
        p0 = r0; p1 = r1;
        for (int i = 0; i < 20 && (p0 || p1); i++) begin
            @(negedge CLK);
            if (ack0) begin req0 = 1'b0; p0 = 1'b0; end
            if (ack1) begin req1 = 1'b0; p1 = 1'b0; end
        end
        check("ack_timeout", {p1, p0}, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge CLK);
        check("busy_idle", busy, 0);
        check("strobe_count", strobes, ns);
        check("stack_depth", sp_cnt, ref_stk.size());
        check("sb_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic model_reset();
        ref_stk.delete();
        sbq.delete();
        rdata_m = '0;
        last_m  = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; strobes = 0; round_t = 0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; din0 = '0; din1 = '0;
        RESET = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_outputs", {ack0, ack1, rerr, busy, stk_push, stk_pop}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_dio", stk_dio, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // single push then pop
        do_round(1, 1, 32'hA5, 0, 0, 0);
        do_round(1, 0, 0, 0, 0, 0);
        check("empty_after_pop", stk_empty, 1);

        // contention: both pushing, grants must alternate
        for (int i = 0; i < 3; i++)
            do_round(1, 1, 32'h100 + i, 1, 1, 32'h200 + i);
        for (int i = 0; i < 6; i++)
            do_round(i % 2 == 0, 0, 0, i % 2 == 1, 0, 0);

        // fill to full, then a refused push
        for (int i = 0; i < N; i++)
            do_round(i % 2 == 0, 1, $urandom, i % 2 == 1, 1, $urandom);
        check("full_flag", stk_full, 1);
        do_round(1, 1, 32'h55, 0, 0, 0);
        do_round(1, 1, 32'h56, 1, 1, 32'h57);

        // drain, then a refused pop on empty
        for (int i = 0; i < N; i++)
            do_round(1, 0, 0, 1, 0, 0) ;
        do_round(0, 0, 0, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            do_round(r0, 1'($urandom_range(0, 1)), $urandom, r1, 1'($urandom_range(0, 1)), $urandom);
        end

        // reset while a push strobe is in flight
        req0 = 1'b1; op0 = 1'b1; din0 = 32'h77;
        @(negedge CLK);
        check("issue_strobe", stk_push, 1);
        RESET = 1'b1;
        req0  = 1'b0;
        @(negedge CLK);
        check("midrst_outputs", {ack0, ack1, rerr, busy, stk_push, stk_pop}, 0);
        check("midrst_rdata", rdata, 0);
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        do_round(1, 1, 32'h11, 1, 1, 32'h22);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
